agex_sequencer: RTL and testbench



---
 rtl/agex_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_agex_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/agex_sequencer.sv
// Microsequencer for `OP reg32, r/m32`: AGEN -> MEM_WAIT -> WB for memory forms, REG_LD -> WB for register forms.
// Optional: define AGEX_SEQ_PERF_EN to add the perf_insn / perf_stall counters.
module agex_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] modrm_in,
  input  logic [1:0] aluk_in,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       mem_req,
  output logic       gate_addr_gen,
  output logic       gate_alu,
  output logic [2:0] sr1_select,
  output logic       sr1_re,
  output logic [2:0] sr2_select,
  output logic       sr2_re,
  output logic [2:0] dr_select,
  output logic       dr_we,
  output logic [1:0] alu_shf_mux_s,
  output logic       en_alu_shf,
  output logic       sr1_mux_s,
  output logic [1:0] sr2_mux_s,
  output logic [1:0] aluk
`ifdef AGEX_SEQ_PERF_EN
  ,
  output logic [15:0] perf_insn,
  output logic [15:0] perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AGEN,
    S_MEM_WAIT,
    S_REG_LD,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] modrm_q, modrm_d;
  logic [1:0] aluk_q, aluk_d;
  logic       err_flag_q, err_flag_d;

  logic [1:0] mod_q;
  logic [2:0] reg_q;
  logic [2:0] rm_q;
  assign mod_q = modrm_q[7:6];
  assign reg_q = modrm_q[5:3];
  assign rm_q  = modrm_q[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      modrm_q    <= '0;
      aluk_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      modrm_q    <= modrm_d;
      aluk_q     <= aluk_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    modrm_d       = modrm_q;
    aluk_d        = aluk_q;
    err_flag_d    = err_flag_q;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    err           = 1'b0;
    mem_req       = 1'b0;
    gate_addr_gen = 1'b0;
    gate_alu      = 1'b0;
    sr1_select    = 3'b000;
    sr1_re        = 1'b0;
    sr2_select    = 3'b000;
    sr2_re        = 1'b0;
    dr_select     = 3'b000;
    dr_we         = 1'b0;
    alu_shf_mux_s = 2'b00;
    en_alu_shf    = 1'b0;
    sr1_mux_s     = 1'b0;
    sr2_mux_s     = 2'b00;
    aluk          = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          modrm_d = modrm_in;
          aluk_d  = aluk_in;
          // rm=100 outside register mode needs a SIB byte, which is not supported
          if (modrm_in[2:0] == 3'b100 && modrm_in[7:6] != 2'b11) begin
            state_d    = S_DONE;
            err_flag_d = 1'b1;
          end else if (modrm_in[7:6] == 2'b11) begin
            state_d = S_REG_LD;
          end else begin
            state_d = S_AGEN;
          end
        end
      end
      S_AGEN: begin
        gate_addr_gen = 1'b1;
        mem_req       = 1'b1;
        sr1_select    = rm_q;
        sr1_re        = !(mod_q == 2'b00 && rm_q == 3'b101);
        cnt_d         = '0;
        state_d       = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        alu_shf_mux_s = 2'b11;
        en_alu_shf    = mem_ack;
        if (mem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == WAIT_LAST) begin
          state_d    = S_DONE;
          err_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REG_LD: begin
        sr2_select    = rm_q;
        sr2_re        = 1'b1;
        alu_shf_mux_s = 2'b10;
        en_alu_shf    = 1'b1;
        state_d       = S_WB;
      end
      S_WB: begin
        sr2_select = reg_q;
        sr2_re     = 1'b1;
        sr1_mux_s  = 1'b1;
        sr2_mux_s  = 2'b00;
        aluk       = aluk_q;
        gate_alu   = 1'b1;
        dr_select  = reg_q;
        dr_we      = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        err        = err_flag_q;
        err_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef AGEX_SEQ_PERF_EN
  logic [15:0] perf_insn_q, perf_insn_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_insn_d  = perf_insn_q;
    perf_stall_d = perf_stall_q;
    if (state_q == S_DONE && !err_flag_q) begin
      perf_insn_d = perf_insn_q + 16'd1;
    end
    if (state_q == S_MEM_WAIT && !mem_ack) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_insn_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_insn_q  <= perf_insn_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_insn  = perf_insn_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_agex_sequencer.sv
// Directed bench for agex_sequencer: control-line decode, latencies, timeout/SIB aborts and reset abort.
module tb_agex_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] modrm_in;
  logic [1:0] aluk_in;
  logic       mem_ack;
  logic       busy, done, err, mem_req, gate_addr_gen, gate_alu;
  logic [2:0] sr1_select, sr2_select, dr_select;
  logic       sr1_re, sr2_re, dr_we, en_alu_shf, sr1_mux_s;
  logic [1:0] alu_shf_mux_s, sr2_mux_s, aluk;
`ifdef AGEX_SEQ_PERF_EN
  logic [15:0] perf_insn, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int done_cnt = 0;
  int dr_we_cnt = 0;
  int mem_req_cnt = 0;
  int overlap_cnt = 0;
  logic       agen_sr1_re = 1'b0;
  logic       agen_gate = 1'b0;
  logic [2:0] agen_sel = 3'b000;

  logic [25:0] all_out;
  assign all_out = {busy, done, err, mem_req, gate_addr_gen, gate_alu, sr1_select, sr1_re,
                    sr2_select, sr2_re, dr_select, dr_we, alu_shf_mux_s, en_alu_shf,
                    sr1_mux_s, sr2_mux_s, aluk};

  agex_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .modrm_in(modrm_in), .aluk_in(aluk_in),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err), .mem_req(mem_req),
    .gate_addr_gen(gate_addr_gen), .gate_alu(gate_alu), .sr1_select(sr1_select),
    .sr1_re(sr1_re), .sr2_select(sr2_select), .sr2_re(sr2_re), .dr_select(dr_select),
    .dr_we(dr_we), .alu_shf_mux_s(alu_shf_mux_s), .en_alu_shf(en_alu_shf),
    .sr1_mux_s(sr1_mux_s), .sr2_mux_s(sr2_mux_s), .aluk(aluk)
`ifdef AGEX_SEQ_PERF_EN
    , .perf_insn(perf_insn), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: event counters and AGEN snapshot.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dr_we) dr_we_cnt++;
    if (gate_addr_gen && gate_alu) overlap_cnt++;
    if (mem_req) begin
      mem_req_cnt++;
      agen_sr1_re = sr1_re;
      agen_gate   = gate_addr_gen;
      agen_sel    = sr1_select;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one instruction, ack the ack_at-th MEM_WAIT cycle (0 = never), return cycles to done.
  task automatic run_insn(input logic [7:0] m, input logic [1:0] a, input int ack_at,
                          output int lat, output logic e);
    int w;
    w = 0;
    lat = 0;
    e = 1'b0;
    modrm_in = m;
    aluk_in  = a;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        e = err;
        break;
      end
      if (busy && alu_shf_mux_s == 2'b11) begin
        w++;
        if (w == ack_at) mem_ack = 1'b1;
      end
      tick();
      mem_ack = 1'b0;
    end
    tick();
    $display("insn modrm=%02h aluk=%0d ack_at=%0d latency=%0d err=%0d", m, a, ack_at, lat, e);
  endtask

  initial begin
    int lat;
    logic e;
    int d0, w0, r0;

    rst = 1'b1; start = 1'b0; modrm_in = 8'h00; aluk_in = 2'b00; mem_ack = 1'b0;
    repeat (3) tick();
    check("reset_outs", 32'(all_out), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_outs", 32'(all_out), 32'd0);

    // Register form D8: mod=11 reg=011 rm=000
    modrm_in = 8'hD8; aluk_in = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_regld_busy", 32'(busy), 32'd1);
    check("t1_regld_sr2_sel", 32'(sr2_select), 32'd0);
    check("t1_regld_sr2_re", 32'(sr2_re), 32'd1);
    check("t1_regld_mux", 32'(alu_shf_mux_s), 32'd2);
    check("t1_regld_en", 32'(en_alu_shf), 32'd1);
    check("t1_regld_done", 32'(done), 32'd0);
    tick();
    check("t1_wb_dr_sel", 32'(dr_select), 32'd3);
    check("t1_wb_dr_we", 32'(dr_we), 32'd1);
    check("t1_wb_gate_alu", 32'(gate_alu), 32'd1);
    check("t1_wb_gate_addr", 32'(gate_addr_gen), 32'd0);
    check("t1_wb_sr2_sel", 32'(sr2_select), 32'd3);
    check("t1_wb_sr1_mux", 32'(sr1_mux_s), 32'd1);
    check("t1_wb_sr2_mux", 32'(sr2_mux_s), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    tick();
    check("t1_idle", 32'({busy, done}), 32'd0);

    // Memory form 9D (mod=10 reg=011 rm=101), start held with other operands while busy
    modrm_in = 8'h9D; aluk_in = 2'b01; start = 1'b1;
    tick();
    modrm_in = 8'hC1; aluk_in = 2'b11;
    check("t2_agen_sr1_sel", 32'(sr1_select), 32'd5);
    check("t2_agen_sr1_re", 32'(sr1_re), 32'd1);
    check("t2_agen_mem_req", 32'(mem_req), 32'd1);
    check("t2_agen_gate", 32'(gate_addr_gen), 32'd1);
    tick();
    check("t2_mw1_mem_req", 32'(mem_req), 32'd0);
    check("t2_mw1_gates", 32'({gate_addr_gen, gate_alu}), 32'd0);
    check("t2_mw1_mux", 32'(alu_shf_mux_s), 32'd3);
    check("t2_mw1_en", 32'(en_alu_shf), 32'd0);
    tick();
    check("t2_mw2_en", 32'(en_alu_shf), 32'd0);
    check("t2_mw2_busy", 32'(busy), 32'd1);
    tick();
    mem_ack = 1'b1;
    #1;
    check("t2_mw3_en", 32'(en_alu_shf), 32'd1);
    tick();
    mem_ack = 1'b0;
    check("t2_wb_dr_sel", 32'(dr_select), 32'd3);
    check("t2_wb_aluk", 32'(aluk), 32'd1);
    check("t2_wb_dr_we", 32'(dr_we), 32'd1);
    tick();
    check("t2_done_at_6", 32'(done), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    tick();
    check("t2_idle_busy", 32'(busy), 32'd0);
    // start still high here: C1 (mod=11 reg=000 rm=001) is accepted back-to-back
    tick();
    start = 1'b0;
    check("t2b_regld_sr2_sel", 32'(sr2_select), 32'd1);
    check("t2b_regld_en", 32'(en_alu_shf), 32'd1);
    tick();
    check("t2b_wb_aluk", 32'(aluk), 32'd3);
    check("t2b_wb_dr_sel", 32'(dr_select), 32'd0);
    check("t2b_wb_dr_we", 32'(dr_we), 32'd1);
    tick();
    check("t2b_done", 32'(done), 32'd1);
    tick();

    // Disp32-only form 1D, ack on the first MEM_WAIT cycle
    run_insn(8'h1D, 2'b00, 1, lat, e);
    check("t3_latency", 32'(lat), 32'd4);
    check("t3_err", 32'(e), 32'd0);
    check("t3_agen_sr1_re", 32'(agen_sr1_re), 32'd0);
    check("t3_agen_gate", 32'(agen_gate), 32'd1);
    check("t3_agen_sel", 32'(agen_sel), 32'd5);

    // Timeout: no ack for MEM_TIMEOUT=15 cycles
    d0 = done_cnt; w0 = dr_we_cnt; r0 = mem_req_cnt;
    run_insn(8'h9D, 2'b10, 0, lat, e);
    check("t4_latency", 32'(lat), 32'd17);
    check("t4_err", 32'(e), 32'd1);
    check("t4_no_dr_we", 32'(dr_we_cnt - w0), 32'd0);
    check("t4_one_done", 32'(done_cnt - d0), 32'd1);
    check("t4_one_req", 32'(mem_req_cnt - r0), 32'd1);

    // SIB abort
    r0 = mem_req_cnt; w0 = dr_we_cnt;
    run_insn(8'h04, 2'b00, 1, lat, e);
    check("t5_latency", 32'(lat), 32'd1);
    check("t5_err", 32'(e), 32'd1);
    check("t5_no_req", 32'(mem_req_cnt - r0), 32'd0);
    check("t5_no_dr_we", 32'(dr_we_cnt - w0), 32'd0);

    // Reset during MEM_WAIT
    modrm_in = 8'h9D; aluk_in = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t6_in_wait", 32'(alu_shf_mux_s), 32'd3);
    d0 = done_cnt; w0 = dr_we_cnt;
    rst = 1'b1;
    tick();
    check("t6_reset_outs", 32'(all_out), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_no_dr_we", 32'(dr_we_cnt - w0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

`ifdef AGEX_SEQ_PERF_EN
    check("perf_reset_insn", 32'(perf_insn), 32'd0);
    run_insn(8'hD8, 2'b00, 1, lat, e);
    run_insn(8'hC1, 2'b01, 1, lat, e);
    run_insn(8'h9D, 2'b00, 2, lat, e);
    check("perf_insn", 32'(perf_insn), 32'd3);
    check("perf_stall", 32'(perf_stall), 32'd1);
`endif

    check("gate_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
